// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the CPU controller and the datapath it drives.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_WAIT   = 3'd0,
        ST_DECODE = 3'd1,
        ST_GETA   = 3'd2,
        ST_GETB   = 3'd3,
        ST_ALU    = 3'd4,
        ST_WRITE  = 3'd5
    } state_t;

    // Opcode field IR[15:13]
    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    // op field IR[12:11] under OPC_MOV
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;

    // op field IR[12:11] under OPC_ALU (doubles as the ALUop encoding)
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_CMP = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_MVN = 2'b11;

    // ALU operation select
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;

    // Write-back source select
    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_PC    = 2'b01;
    localparam logic [1:0] VSEL_IMM8  = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    // Shifter select
    localparam logic [1:0] SHIFT_NONE = 2'b00;
    localparam logic [1:0] SHIFT_LSL1 = 2'b01;
    localparam logic [1:0] SHIFT_LSR1 = 2'b10;
    localparam logic [1:0] SHIFT_ASR1 = 2'b11;

    // Instruction class flags; exactly one of the class bits is set when legal=1
    typedef struct packed {
        logic mov_imm;
        logic mov_reg;
        logic mvn;
        logic alu3;     // ADD or AND: Rd <= Rn op Rm
        logic cmp;
        logic legal;
    } iclass_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction field split, immediate sign extension and class decode.
module instr_decoder
    import cpu_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [15:0]      ir,
    output logic [1:0]       op,
    output logic [2:0]       rn,
    output logic [2:0]       rd,
    output logic [1:0]       sh,
    output logic [2:0]       rm,
    output logic [WIDTH-1:0] sximm5,
    output logic [WIDTH-1:0] sximm8,
    output iclass_t          cls
);

    logic [2:0] opcode;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];

    assign sximm5 = {{(WIDTH-5){ir[4]}}, ir[4:0]};
    assign sximm8 = {{(WIDTH-8){ir[7]}}, ir[7:0]};

    // Classify the instruction; anything not matched stays illegal
    always_comb begin
        cls = '0;
        if (opcode == OPC_MOV) begin
            cls.mov_imm = (op == OP_MOV_IMM);
            cls.mov_reg = (op == OP_MOV_REG);
        end else if (opcode == OPC_ALU) begin
            cls.alu3 = (op == OP_ADD) || (op == OP_AND);
            cls.cmp  = (op == OP_CMP);
            cls.mvn  = (op == OP_MVN);
        end
        cls.legal = cls.mov_imm | cls.mov_reg | cls.mvn | cls.alu3 | cls.cmp;
    end

endmodule

// File: rtl/cpu_controller.sv
// Instruction register plus multi-cycle control FSM driving the datapath.
//
// state  | meaning
// WAIT   | idle, w=1; load writes IR, s starts the current IR
// DECODE | classify IR, pick first working state (illegal sets err)
// GETA   | read Rn into A
// GETB   | read Rm into B
// ALU    | compute into C (or status only for CMP)
// WRITE  | write result or imm8 back to the register file
module cpu_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    output logic             w,
    output logic [2:0]       readnum,
    output logic [2:0]       writenum,
    output logic [1:0]       vsel,
    output logic             loada,
    output logic             loadb,
    output logic             loadc,
    output logic             loads,
    output logic             write,
    output logic             asel,
    output logic             bsel,
    output logic [1:0]       shift,
    output logic [1:0]       ALUop,
    output logic [WIDTH-1:0] sximm5,
    output logic [WIDTH-1:0] sximm8,
    output logic             err
);

    state_t     state, state_nxt;
    logic [15:0] ir;
    logic [1:0] op;
    logic [2:0] rn, rd, rm;
    logic [1:0] sh;
    iclass_t    cls;

    instr_decoder #(.WIDTH(WIDTH)) u_dec (
        .ir     (ir),
        .op     (op),
        .rn     (rn),
        .rd     (rd),
        .sh     (sh),
        .rm     (rm),
        .sximm5 (sximm5),
        .sximm8 (sximm8),
        .cls    (cls)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_WAIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Instruction register: writable only while idle so it is stable during execution
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ir <= '0;
        end else if (state == ST_WAIT && load) begin
            ir <= in[15:0];
        end
    end

    // Sticky illegal-instruction flag, cleared when the next instruction starts
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (state == ST_WAIT && s) begin
            err <= 1'b0;
        end else if (state == ST_DECODE && !cls.legal) begin
            err <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_WAIT: begin
                if (s) state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                if (cls.mov_imm)                  state_nxt = ST_WRITE;
                else if (cls.mov_reg || cls.mvn)  state_nxt = ST_GETB;
                else if (cls.alu3 || cls.cmp)     state_nxt = ST_GETA;
                else                              state_nxt = ST_WAIT;
            end
            ST_GETA:  state_nxt = ST_GETB;
            ST_GETB:  state_nxt = ST_ALU;
            ST_ALU:   state_nxt = cls.cmp ? ST_WAIT : ST_WRITE;
            ST_WRITE: state_nxt = ST_WAIT;
            default:  state_nxt = ST_WAIT;
        endcase
    end

    // Moore control outputs decoded from state and IR
    always_comb begin
        w        = 1'b0;
        readnum  = 3'd0;
        writenum = 3'd0;
        vsel     = VSEL_C;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        write    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        shift    = SHIFT_NONE;
        ALUop    = ALU_ADD;
        unique case (state)
            ST_WAIT: begin
                w = 1'b1;
            end
            ST_GETA: begin
                readnum = rn;
                loada   = 1'b1;
            end
            ST_GETB: begin
                readnum = rm;
                loadb   = 1'b1;
            end
            ST_ALU: begin
                shift = sh;
                // MOV reg and MVN have no A operand; zero it so A+B / ~B pass B through
                asel  = cls.mov_reg | cls.mvn;
                ALUop = cls.mov_reg ? ALU_ADD : op;
                if (cls.cmp) begin
                    loads = 1'b1;
                end else begin
                    loadc = 1'b1;
                end
            end
            ST_WRITE: begin
                write = 1'b1;
                if (cls.mov_imm) begin
                    writenum = rn;
                    vsel     = VSEL_IMM8;
                end else begin
                    writenum = rd;
                    vsel     = VSEL_C;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: per-cycle control vector checks for each instruction class.
module tb_cpu_controller;

    logic        clk;
    logic        rst_n;
    logic        s;
    logic        load;
    logic [15:0] in;
    logic        w;
    logic [2:0]  readnum, writenum;
    logic [1:0]  vsel;
    logic        loada, loadb, loadc, loads, write, asel, bsel;
    logic [1:0]  shift, ALUop;
    logic [15:0] sximm5, sximm8;
    logic        err;

    int vectors;
    int miscompares;

    logic [19:0] ctl;
    logic [19:0] c_wait;
    logic [19:0] c_idle;

    cpu_controller #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s        (s),
        .load     (load),
        .in       (in),
        .w        (w),
        .readnum  (readnum),
        .writenum (writenum),
        .vsel     (vsel),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .write    (write),
        .asel     (asel),
        .bsel     (bsel),
        .shift    (shift),
        .ALUop    (ALUop),
        .sximm5   (sximm5),
        .sximm8   (sximm8),
        .err      (err)
    );

    assign ctl = {w, readnum, writenum, vsel, loada, loadb, loadc, loads, write,
                  asel, bsel, shift, ALUop};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control vector, fields in the same order as ctl
    function automatic logic [19:0] mk(input logic ww, input logic [2:0] rn, input logic [2:0] wn,
                                       input logic [1:0] vs, input logic la, input logic lb,
                                       input logic lc, input logic ls, input logic wr,
                                       input logic as, input logic bs, input logic [1:0] sh,
                                       input logic [1:0] op);
        return {ww, rn, wn, vs, la, lb, lc, ls, wr, as, bs, sh, op};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        c_wait = mk(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        c_idle = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        rst_n = 1'b0;
        s     = 1'b0;
        load  = 1'b0;
        in    = 16'h0000;
        step();
        step();
        rst_n = 1'b1;
        chk("reset_ctl", ctl, c_wait);
        chk("reset_imm5", {4'h0, sximm5}, 20'h0);
        chk("reset_imm8", {4'h0, sximm8}, 20'h0);
        chk("reset_err", {19'h0, err}, 20'h0);

        // MOV R1,#5 with load and s together
        in = 16'hD105; load = 1'b1; s = 1'b1;
        step();
        load = 1'b0; s = 1'b0;
        chk("movi_decode", ctl, c_idle);
        chk("movi_imm8", {4'h0, sximm8}, 20'h00005);
        step();
        chk("movi_write", ctl, mk(0, 0, 1, 2'b10, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
        step();
        chk("movi_wait", ctl, c_wait);

        // MOV R2,#-1: load alone, then start
        in = 16'hD2FF; load = 1'b1;
        step();
        load = 1'b0;
        chk("movi2_loaded_w", ctl, c_wait);
        chk("movi2_imm8", {4'h0, sximm8}, 20'h0FFFF);
        chk("movi2_imm5", {4'h0, sximm5}, 20'h0FFFF);
        s = 1'b1;
        step();
        s = 1'b0;
        chk("movi2_decode", ctl, c_idle);
        step();
        chk("movi2_write", ctl, mk(0, 0, 2, 2'b10, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
        step();
        chk("movi2_wait", ctl, c_wait);

        // ADD R5,R0,R1,LSL1; load attempts during execution must be ignored
        in = 16'hA0A9; load = 1'b1; s = 1'b1;
        step();
        s = 1'b0; in = 16'hFFFF;
        chk("add_decode", ctl, c_idle);
        step();
        chk("add_geta", ctl, mk(0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        step();
        chk("add_getb", ctl, mk(0, 1, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        step();
        chk("add_alu", ctl, mk(0, 0, 0, 2'b00, 0, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00));
        step();
        load = 1'b0; in = 16'h0000;
        chk("add_write", ctl, mk(0, 0, 5, 2'b00, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
        chk("add_ir_imm5", {4'h0, sximm5}, 20'h00009);
        chk("add_ir_imm8", {4'h0, sximm8}, 20'h0FFA9);
        step();
        chk("add_wait", ctl, c_wait);

        // CMP R1,R1: status only, no write
        in = 16'hA901; load = 1'b1; s = 1'b1;
        step();
        load = 1'b0; s = 1'b0;
        chk("cmp_decode", ctl, c_idle);
        step();
        chk("cmp_geta", ctl, mk(0, 1, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        step();
        chk("cmp_getb", ctl, mk(0, 1, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        step();
        chk("cmp_alu", ctl, mk(0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b01));
        step();
        chk("cmp_wait", ctl, c_wait);

        // MOV R7,R3,LSR1
        in = 16'hC0F3; load = 1'b1; s = 1'b1;
        step();
        load = 1'b0; s = 1'b0;
        chk("movr_decode", ctl, c_idle);
        step();
        chk("movr_getb", ctl, mk(0, 3, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        step();
        chk("movr_alu", ctl, mk(0, 0, 0, 2'b00, 0, 0, 1, 0, 0, 1, 0, 2'b10, 2'b00));
        step();
        chk("movr_write", ctl, mk(0, 0, 7, 2'b00, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
        step();
        chk("movr_wait", ctl, c_wait);

        // MVN R7,R2
        in = 16'hB8E2; load = 1'b1; s = 1'b1;
        step();
        load = 1'b0; s = 1'b0;
        chk("mvn_decode", ctl, c_idle);
        step();
        chk("mvn_getb", ctl, mk(0, 2, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        step();
        chk("mvn_alu", ctl, mk(0, 0, 0, 2'b00, 0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b11));
        step();
        chk("mvn_write", ctl, mk(0, 0, 7, 2'b00, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
        step();
        chk("mvn_wait", ctl, c_wait);

        // Illegal 0xF000: err set, no strobes; s held high re-issues and clears err
        in = 16'hF000; load = 1'b1; s = 1'b1;
        step();
        load = 1'b0; s = 1'b0;
        chk("ill_decode", ctl, c_idle);
        chk("ill_err_decode", {19'h0, err}, 20'h0);
        step();
        chk("ill_wait", ctl, c_wait);
        chk("ill_err_set", {19'h0, err}, 20'h1);
        s = 1'b1;
        step();
        chk("ill_reissue_decode", ctl, c_idle);
        chk("ill_err_cleared", {19'h0, err}, 20'h0);
        step();
        chk("ill_reissue_wait", ctl, c_wait);
        chk("ill_err_set2", {19'h0, err}, 20'h1);
        step();
        s = 1'b0;
        chk("ill_held_s_decode", ctl, c_idle);
        chk("ill_held_s_err", {19'h0, err}, 20'h0);
        step();
        chk("ill_err_set3", {19'h0, err}, 20'h1);

        // Reset during GETB of ADD aborts the instruction
        in = 16'hA0A9; load = 1'b1; s = 1'b1;
        step();
        load = 1'b0; s = 1'b0;
        chk("rst_add_decode", ctl, c_idle);
        chk("rst_err_cleared", {19'h0, err}, 20'h0);
        step();
        chk("rst_add_geta", ctl, mk(0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        step();
        chk("rst_add_getb", ctl, mk(0, 1, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst_abort_ctl", ctl, c_wait);
        chk("rst_abort_imm8", {4'h0, sximm8}, 20'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rst_no_write", ctl, c_wait);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Instruction register, decoder and multi-cycle control FSM sitting directly upstream of the datapath. Latches a 16-bit instruction, sign-extends its immediates and sequences the datapath's register reads, ALU pass and write-back over several cycles. Drives every datapath control input; exposes a `w` (waiting) flag to the top level.

## Interface
- `WIDTH`, 16: instruction and immediate width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `s` in 1: start; sampled only in WAIT.
- `load` in 1: load `in` into IR; honoured only in WAIT.
- `in` in 16: instruction word.
- `w` out 1: 1 while in WAIT (ready for load/start).
- `readnum`, `writenum` out 3: register select.
- `vsel` out 2: write-back source; 00 C, 01 PC, 10 sximm8, 11 mdata.
- `loada`, `loadb`, `loadc`, `loads`, `write` out 1: datapath load/write strobes.
- `asel` out 1: 1 forces A operand to zero. `bsel` out 1: 1 selects sximm5.
- `shift` out 2: 00 none, 01 LSL1, 10 LSR1, 11 ASR1.
- `ALUop` out 2: 00 ADD, 01 SUB, 10 AND, 11 NOT B.
- `sximm5`, `sximm8` out 16: sign-extended IR[4:0], IR[7:0].
- `err` out 1: sticky; set on illegal instruction, cleared by reset or next `s`.

## Operation
- Instruction fields: opcode IR[15:13], op IR[12:11], Rn IR[10:8], Rd IR[7:5], sh IR[4:3], Rm IR[2:0].
- Legal: 110/10 MOV Rn,#imm8; 110/00 MOV Rd,Rm{,sh}; 101/00 ADD Rd,Rn,Rm; 101/01 CMP Rn,Rm; 101/10 AND Rd,Rn,Rm; 101/11 MVN Rd,Rm. All others illegal.
- States: WAIT, DECODE, GETA, GETB, ALU, WRITE.
- WAIT: `w`=1; `load` writes IR; `s`=1 → DECODE (if `load` and `s` together, new IR is used).
- DECODE: MOV imm → WRITE; MOV reg/MVN → GETB; ADD/CMP/AND → GETA; illegal → WAIT, `err`=1, no strobes.
- GETA: readnum=Rn, loada=1 → GETB.
- GETB: readnum=Rm, loadb=1 → ALU.
- ALU: loadc=1; shift=sh; asel=1 for MOV reg/MVN else 0; bsel=0; ALUop = ADD for MOV reg, else from op. CMP: loads=1, loadc=0 → WAIT. Others → WRITE.
- WRITE: write=1; MOV imm: writenum=Rn, vsel=10; else writenum=Rd, vsel=00 → WAIT.
- All control outputs Moore (function of state and IR only); strobes 0 in every state not listed.
- `loads` asserted only by CMP.

## Timing
- Reset (rst_n=0 at edge): state WAIT, IR=0, err=0; hence w=1, all strobes 0, readnum=writenum=0, vsel=00, shift=00, ALUop=00, asel=bsel=0, sximm5=sximm8=0.
- Reset mid-instruction aborts at next edge; no further strobes.
- Cycles from `s` edge back to `w`=1: MOV imm 3, MOV reg/MVN 5, CMP 5, ADD/AND 6, illegal 2.
- IR stable from DECODE until return to WAIT; `load` outside WAIT ignored.
- `s` held high in WAIT immediately re-issues the current IR.

## Structure
- Package `cpu_ctrl_pkg`: state enum, opcode/op constants, ALUop, vsel and shift encodings (shared with datapath).
- Sub-module `instr_decoder`: combinational field split, sign extension, legal/class flags.

## Test plan
- Reset, then load 0xD105 (MOV R1,#5), s → sximm8=0x0005, WRITE with writenum=1, vsel=10, write=1; w back after 3 cycles.
- Load 0xD2FF (MOV R2,#-1) → sximm8=0xFFFF.
- Load 0xA0A9 (ADD R5,R0,R1,LSL1 — Rd=5, sh=01) → GETA readnum=0, GETB readnum=1, ALU shift=01 ALUop=00 asel=0, WRITE writenum=5; 6 cycles.
- Load 0xA901 (CMP R1,R1) → loads=1 in ALU, write never asserted; 5 cycles.
- Load 0xF000 (illegal) → err=1 after DECODE, no strobes, w=1 after 2 cycles; next `s` clears err.
- Drive rst_n=0 during GETB of ADD → state WAIT, all strobes 0 next cycle, no write ever issued.
